// File: rtl/divn_serial.sv
// Serial divisibility checker: computes inp mod DIVISOR one bit per clock,
// MSB first, with a one-cycle done pulse and held result registers.
module divn_serial #(
  parameter int WIDTH   = 16,
  parameter int DIVISOR = 11,
  parameter int RW      = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inp,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    remainder,
  output logic             divisible
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [RW:0] DIV = (RW+1)'(DIVISOR);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [RW-1:0]    r;
  logic [CW-1:0]    cnt;
  logic [RW:0]      t;
  logic [RW-1:0]    r_next;
  logic             last;

  // r < DIVISOR keeps t < 2*DIVISOR, so one conditional subtract suffices
  always_comb begin
    t      = {r, shreg[WIDTH-1]};
    r_next = (t >= DIV) ? RW'(t - DIV) : RW'(t);
    last   = (cnt == CW'(WIDTH-1));
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      r         <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      remainder <= '0;
      divisible <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg <= inp;
            r     <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          r     <= r_next;
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            remainder <= r_next;
            divisible <= (r_next == '0);
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divn_serial.sv
// Directed bench for divn_serial: default (16,11) table and corner
// sequences, plus (8,7) exhaustive and (1,2) instances.
module tb_divn_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0;
  logic [15:0] inp0 = '0;
  logic        busy0, done0, div0;
  logic [3:0]  rem0;

  logic        start8 = 1'b0;
  logic [7:0]  inp8 = '0;
  logic        busy8, done8, div8;
  logic [2:0]  rem8;

  logic        start1 = 1'b0;
  logic [0:0]  inp1 = '0;
  logic        busy1, done1, div1;
  logic [0:0]  rem1;

  divn_serial dut0 (
    .clk(clk), .rst(rst), .start(start0), .inp(inp0),
    .busy(busy0), .done(done0), .remainder(rem0), .divisible(div0)
  );

  divn_serial #(.WIDTH(8), .DIVISOR(7)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .inp(inp8),
    .busy(busy8), .done(done8), .remainder(rem8), .divisible(div8)
  );

  divn_serial #(.WIDTH(1), .DIVISOR(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .inp(inp1),
    .busy(busy1), .done(done1), .remainder(rem1), .divisible(div1)
  );

  int tests = 0;
  int fails = 0;
  int dcnt  = 0;

  always @(negedge clk) if (done0) dcnt++;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  rem;
    logic        dv;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // wait on dut0 done, counting cycles and busy cycles
  task automatic wait_done0(output int cyc, output int bcyc);
    cyc = 0;
    bcyc = 0;
    while (!done0 && cyc < 100) begin
      if (busy0) bcyc++;
      @(negedge clk);
      cyc++;
    end
    if (!done0) chk("done0_timeout", 0, 1);
  endtask

  task automatic op0(input logic [15:0] v, input int erem,
                     input int edv, input string name);
    int cyc, bcyc;
    @(negedge clk);
    inp0 = v;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(cyc, bcyc);
    chk({name, "_lat"}, cyc, 16);
    chk({name, "_rem"}, int'(rem0), erem);
    chk({name, "_div"}, int'(div0), edv);
  endtask

  vec_t tab[$];

  initial begin
    int cyc, bcyc, c, d0;

    tab.push_back('{16'h0022, 4'd1, 1'b0});
    tab.push_back('{16'h9090, 4'd4, 1'b0});
    tab.push_back('{16'h9097, 4'd0, 1'b1});
    tab.push_back('{16'hFFFF, 4'd8, 1'b0});
    tab.push_back('{16'h0000, 4'd0, 1'b1});

    #12;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_rem", int'(rem0), 0);
    chk("rst_div", int'(div0), 0);
    @(negedge clk);
    rst = 1'b0;

    // first op: 17 mod 11, busy exactly 16 cycles
    @(negedge clk);
    inp0 = 16'h0011;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(cyc, bcyc);
    chk("op17_lat", cyc, 16);
    chk("op17_busy", bcyc, 16);
    chk("op17_busy_at_done", int'(busy0), 0);
    chk("op17_rem", int'(rem0), 6);
    chk("op17_div", int'(div0), 0);
    @(negedge clk);
    chk("op17_done_1cyc", int'(done0), 0);
    chk("op17_rem_hold", int'(rem0), 6);

    foreach (tab[i])
      op0(tab[i].v, int'(tab[i].rem), int'(tab[i].dv),
          $sformatf("tab%0d", i));

    // back-to-back with start held through done
    @(negedge clk);
    inp0 = 16'h9097;
    start0 = 1'b1;
    @(negedge clk);
    wait_done0(cyc, bcyc);
    chk("b2b_a_rem", int'(rem0), 0);
    chk("b2b_a_div", int'(div0), 1);
    inp0 = 16'h0012;
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b_nogap_busy", int'(busy0), 1);
    chk("b2b_nogap_done", int'(done0), 0);
    c = 1;
    while (!done0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_spacing", c, 17);
    chk("b2b_b_rem", int'(rem0), 7);
    chk("b2b_b_div", int'(div0), 0);

    // start and inp disturbed mid-run
    repeat (3) @(negedge clk);
    d0 = dcnt;
    inp0 = 16'h0022;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rem_untouched", int'(rem0), 7);
    inp0 = 16'hFFFF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    inp0 = 16'h1234;
    wait_done0(cyc, bcyc);
    chk("mid_rem", int'(rem0), 1);
    repeat (30) @(negedge clk);
    chk("mid_one_done", dcnt - d0, 1);

    // reset mid-run aborts
    @(negedge clk);
    inp0 = 16'h9090;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (8) @(negedge clk);
    d0 = dcnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_rem", int'(rem0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_done", int'(done0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst_no_done", dcnt - d0, 0);
    op0(16'h0011, 6, 0, "post_rst");

    // WIDTH=8, DIVISOR=7 exhaustive
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      inp8 = 8'(v);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      c = 0;
      while (!done8 && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c != 8) chk($sformatf("w8_lat_%0d", v), c, 8);
      chk($sformatf("w8_rem_%0d", v), int'(rem8), v % 7);
      if (div8 !== ((v % 7) == 0))
        chk($sformatf("w8_div_%0d", v), int'(div8), int'((v % 7) == 0));
    end

    // WIDTH=1, DIVISOR=2
    for (int v = 1; v >= 0; v--) begin
      @(negedge clk);
      inp1 = 1'(v);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk($sformatf("w1_busy_%0d", v), int'(busy1), 1);
      @(negedge clk);
      chk($sformatf("w1_done_%0d", v), int'(done1), 1);
      chk($sformatf("w1_rem_%0d", v), int'(rem1), v);
      chk($sformatf("w1_div_%0d", v), int'(div1), int'(v == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
